serial_adder: RTL
=================

# serial_adder

Parametrised multi-cycle adder that reduces a WIDTH-bit addition to WIDTH/DIGIT passes through one DIGIT-bit full-adder slice, with a registered carry between passes. Operands enter through a valid/ready handshake and results leave through a second one. It is the sequential, width-generic successor to the single-bit full adder cell, intended for area-constrained datapaths where an addition may take several cycles.

## Interface
- WIDTH, 8, operand/result width; must be at least 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT passes.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands on a, b, ci (and sub) are valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in
- sub  input  1  subtract select (present only with SERIAL_ADDER_SUB_EN)
- out_valid  output  1  s, co and ovf are valid
- out_ready  input  1  consumer takes the result
- s  output  WIDTH  sum
- co  output  1  final carry-out
- ovf  output  1  two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - in_valid captures a, b, ci (and sub) into operand shift registers, loads the carry register with the effective carry-in, clears the pass counter, and moves to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle adds the low DIGIT bits of both operand registers plus the carry register.
  - The DIGIT-bit result shifts into the top of the sum register. The slice carry-out updates the carry register. Both operand registers shift right by DIGIT.
  - On the pass where counter = N-1, the FSM registers co = slice carry-out and ovf = carry into MSB XOR carry out of MSB, then moves to DONE.
- DONE:
  - out_valid = 1. s, co and ovf stay stable. in_ready = 0.
  - out_valid && out_ready returns the FSM to IDLE.
  - A new operation is accepted no earlier than the following cycle. in_valid is ignored while the FSM is not in IDLE.
- Arithmetic: {co, s} = a + b + ci, modulo 2^(WIDTH+1). ovf follows the signed overflow rule.
- Reset mid-operation: the in-flight operation is discarded. No partial result is ever presented.

## Timing
- Reset values: in_ready = 1, out_valid = 0, s = 0, co = 0, ovf = 0. Counter and carry register are 0.
- Latency: an operation accepted at clock edge k asserts out_valid after edge k+N.
- Best-case throughput: one operation per N+2 cycles (accept, N passes, one DONE cycle with out_ready high).
- in_ready is a function of state only, with no combinational path from in_valid. out_valid is registered.
- Backpressure: DONE holds indefinitely while out_ready = 0.
- N = 1 (DIGIT = WIDTH) is legal. RUN then lasts exactly one cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is captured at accept.
  - sub = 1 computes a - b - ci by using ~b as the B operand and ~ci as the initial carry.
  - In subtract mode, co = 1 means no borrow. ovf uses the same MSB-carry rule.
- SERIAL_ADDER_SUB_EN undefined:
  - The sub port is absent and the block only adds.
  - No inverter or mux logic is present in the operand path.

## Structure
- Package serial_adder_pkg holds:
  - the state typedef (IDLE/RUN/DONE) and its encoding;
  - a helper constant/function for the counter width, $clog2(N) with a minimum of 1.
- Sub-module fa_digit: a combinational DIGIT-bit ripple of full-adder cells. It outputs the sum, the carry-out, and the carry into its top bit (needed for ovf). The top level instantiates it once.

## Test plan
- WIDTH=8, DIGIT=1: a=0x0F, b=0x01, ci=0 -> s=0x10, co=0, ovf=0. out_valid rises 8 cycles after accept.
- a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, ovf=0. Then a=0x7F, b=0x01, ci=0 -> s=0x80, co=0, ovf=1.
- Backpressure, hold out_ready=0 for 5 cycles in DONE while in_valid pulses:
  - s, co and ovf stay stable and in_ready stays 0;
  - the pulsed operands are not captured;
  - after out_ready, in_ready=1 on the next cycle.
- Assert rst_n low during the 3rd RUN cycle -> out_valid=0, in_ready=1, s=0 immediately. Then a=0x20, b=0x22, ci=1 -> s=0x43.
- WIDTH=8, DIGIT=4: a=0x9C, b=0x64, ci=0 -> s=0x00, co=1, ovf=0, with out_valid 2 cycles after accept.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07, ci=0 -> s=0xFE, co=0, ovf=0. Then sub=1, a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the serial adder
// Optional feature macro used by this block: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  // Control FSM: accept operands, run N digit passes, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pass counter width: enough to count N passes, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// rtl/serial_adder_fa_digit.sv - combinational DIGIT-bit ripple of full-adder cells
// Exposes the carry into the top bit so the caller can derive signed overflow.
module fa_digit
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle WIDTH-bit adder built from one DIGIT-bit slice
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b - ci via ~b and ~ci).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_shift;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             co_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;
  logic             accept;
  logic             last_pass;

  // Subtraction folds into the adder as a + ~b + ~ci; the add-only build wires operands straight through.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign ci_eff = ci ^ sub;
`else
  assign b_eff  = b;
  assign ci_eff = ci;
`endif

  assign accept    = (state == IDLE) && in_valid;
  assign last_pass = (state == RUN) && (cnt_q == LAST);

  fa_digit #(
    .DIGIT (DIGIT)
  ) u_fa_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // New digit enters at the top; after N passes the first digit has reached bit 0.
  if (N == 1) begin : g_single
    assign s_shift = slice_s;
  end else begin : g_multi
    assign s_shift = {slice_s, s_q[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, leave RUN on the last pass, leave DONE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_pass) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode: in_ready depends on state only.
  always_comb begin
    in_ready = 1'b0;
    if (state == IDLE) in_ready = 1'b1;
  end

  // Datapath: load operands on accept, shift one digit per RUN cycle, latch flags on the last pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= a;
        b_q     <= b_eff;
        carry_q <= ci_eff;
        cnt_q   <= '0;
      end else if (state == RUN) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        s_q     <= s_shift;
        carry_q <= slice_co;
        cnt_q   <= cnt_q + 1'b1;
        if (last_pass) begin
          co_q  <= slice_co;
          ovf_q <= slice_cmsb ^ slice_co;
        end
      end
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule
